// File: rtl/mem_arbiter.sv
module mem_arbiter #(
  parameter int unsigned IF_BYTES = 4,
  parameter logic [31:0] IO_BASE  = 32'h30000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_done,
  output logic [8*IF_BYTES-1:0] if_data,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_size,
  input  logic [31:0]           ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic                  flush,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr
);

  localparam int unsigned RB = (IF_BYTES > 4) ? IF_BYTES : 4;
  localparam int unsigned CW = $clog2(RB + 3);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, IO_WAIT} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cyc, cyc_nx;
  logic [CW-1:0]   nbeats, nbeats_nx;
  logic [31:0]     base, base_nx;
  logic [31:0]     wdata, wdata_nx;
  logic            io_low, io_low_nx;
  logic            last_ls, last_ls_nx;
  logic [8*RB-1:0] rbuf, rbuf_nx;
  logic            wr_beat, wr_beat_nx;
  logic [31:0]     mem_a_nx;
  logic [7:0]      mem_dout_nx;
  logic            if_done_nx, ls_done_nx;
  logic [8*IF_BYTES-1:0] if_data_nx;
  logic [31:0]     ls_rdata_nx;
  logic            issue_rd, issue_wr;
  logic            if_go, is_io;
  logic [CW-1:0]   ls_beats;

  assign if_go    = if_req && !flush;
  assign is_io    = (base[17:16] == IO_BASE[17:16]);
  assign ls_beats = ls_size[1] ? CW'(4) : (ls_size[0] ? CW'(2) : CW'(1));
  assign mem_wr   = wr_beat && rdy_in;

  always_comb begin
    state_nx    = state;
    cyc_nx      = cyc;
    nbeats_nx   = nbeats;
    base_nx     = base;
    wdata_nx    = wdata;
    io_low_nx   = io_low;
    last_ls_nx  = last_ls;
    rbuf_nx     = rbuf;
    mem_a_nx    = mem_a;
    mem_dout_nx = mem_dout;
    wr_beat_nx  = 1'b0;
    if_done_nx  = 1'b0;
    ls_done_nx  = 1'b0;
    if_data_nx  = if_data;
    ls_rdata_nx = ls_rdata;
    issue_rd    = 1'b0;
    issue_wr    = 1'b0;

    unique case (state)
      IDLE: begin
        // Load/store wins unless it also won last time and a fetch is waiting.
        if (ls_req && !(if_go && last_ls)) begin
          state_nx   = ls_wr ? LS_WR : LS_RD;
          base_nx    = ls_addr;
          wdata_nx   = ls_wdata;
          nbeats_nx  = ls_beats;
          last_ls_nx = 1'b1;
          cyc_nx     = '0;
          io_low_nx  = 1'b0;
          rbuf_nx    = '0;
        end else if (if_go) begin
          state_nx   = IF_RD;
          base_nx    = if_addr;
          nbeats_nx  = CW'(IF_BYTES);
          last_ls_nx = 1'b0;
          cyc_nx     = '0;
          rbuf_nx    = '0;
        end
      end
      IF_RD, LS_RD: begin
        if (state == IF_RD && flush) begin
          state_nx = IDLE;
        end else begin
          issue_rd = (cyc < nbeats);
          // Byte for beat k arrives two counts after it was issued.
          if (cyc >= CW'(2)) begin
            for (int unsigned i = 0; i < RB; i++) begin
              if (32'(cyc - CW'(2)) == i) rbuf_nx[8*i +: 8] = mem_din;
            end
          end
          if (cyc == nbeats + CW'(1)) begin
            state_nx = IDLE;
            if (state == IF_RD) begin
              if_done_nx = 1'b1;
              if_data_nx = rbuf_nx[8*IF_BYTES-1:0];
            end else begin
              ls_done_nx  = 1'b1;
              ls_rdata_nx = rbuf_nx[31:0];
            end
          end else begin
            cyc_nx = cyc + CW'(1);
          end
        end
      end
      LS_WR: begin
        if (cyc == nbeats) begin
          ls_done_nx = 1'b1;
          state_nx   = IDLE;
        end else if (is_io && io_buffer_full) begin
          state_nx  = IO_WAIT;
          io_low_nx = 1'b0;
        end else begin
          issue_wr = 1'b1;
        end
      end
      IO_WAIT: begin
        // Require two consecutive not-full samples to cover the UART status lag.
        if (io_buffer_full) begin
          io_low_nx = 1'b0;
        end else if (!io_low) begin
          io_low_nx = 1'b1;
        end else begin
          issue_wr  = 1'b1;
          io_low_nx = 1'b0;
          state_nx  = LS_WR;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (issue_rd || issue_wr) mem_a_nx = base + 32'(cyc);
    if (issue_wr) begin
      wr_beat_nx = 1'b1;
      cyc_nx     = cyc + CW'(1);
      for (int unsigned i = 0; i < 4; i++) begin
        if (32'(cyc) == i) mem_dout_nx = wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      cyc      <= '0;
      nbeats   <= '0;
      base     <= '0;
      wdata    <= '0;
      io_low   <= 1'b0;
      last_ls  <= 1'b0;
      rbuf     <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      wr_beat  <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy_in) begin
      state    <= state_nx;
      cyc      <= cyc_nx;
      nbeats   <= nbeats_nx;
      base     <= base_nx;
      wdata    <= wdata_nx;
      io_low   <= io_low_nx;
      last_ls  <= last_ls_nx;
      rbuf     <= rbuf_nx;
      mem_a    <= mem_a_nx;
      mem_dout <= mem_dout_nx;
      wr_beat  <= wr_beat_nx;
      if_done  <= if_done_nx;
      ls_done  <= ls_done_nx;
      if_data  <= if_data_nx;
      ls_rdata <= ls_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req, ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        flush, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:4095];
  logic [7:0] store_bytes [4];

  always #5 clk_in = ~clk_in;

  // RAM read port: byte for the address of one cycle returns the next; shares the global enable.
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= ram[mem_a[11:0]];
  end

  mem_arbiter #(.IF_BYTES(4), .IO_BASE(32'h30000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .flush(flush), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'h11; ram[12'h201] = 8'h22; ram[12'h202] = 8'hAB; ram[12'h203] = 8'hCD;
    store_bytes[0] = 8'hEF; store_bytes[1] = 8'hBE; store_bytes[2] = 8'hAD; store_bytes[3] = 8'hDE;

    rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    flush = 1'b0; io_buffer_full = 1'b0;
    tick(); tick();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_if_done", 32'(if_done), 32'h0);
    check("rst_ls_done", 32'(ls_done), 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b0;

    // Fetch of 4 bytes at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("fetch_mem_a", mem_a, 32'h100 + 32'(c - 1));
      check("fetch_mem_wr", 32'(mem_wr), 32'h0);
    end
    tick();
    check("fetch_done_early", 32'(if_done), 32'h0);
    tick();
    check("fetch_done", 32'(if_done), 32'h1);
    check("fetch_data", if_data, 32'h0000_0513);
    if_req = 1'b0;
    tick();
    check("fetch_done_pulse", 32'(if_done), 32'h0);

    // Halfword load with a concurrent fetch
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h202;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick(); check("lh_mem_a0", mem_a, 32'h202);
    tick(); check("lh_mem_a1", mem_a, 32'h203);
    tick(); check("lh_done_early", 32'(ls_done), 32'h0);
    tick();
    check("lh_done", 32'(ls_done), 32'h1);
    check("lh_rdata", ls_rdata, 32'h0000_CDAB);
    ls_req = 1'b0;
    tick(); check("lh_done_pulse", 32'(ls_done), 32'h0);
    tick(); check("lh_next_fetch_a", mem_a, 32'h100);
    repeat (5) tick();
    check("lh_next_fetch_done", 32'(if_done), 32'h1);
    check("lh_next_fetch_data", if_data, 32'h0000_0513);
    if_req = 1'b0;

    // Word store; request inputs change after grant
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h10; ls_wdata = 32'hDEAD_BEEF;
    tick();
    ls_wdata = 32'h1234_5678; ls_addr = 32'h999;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("sw_mem_wr", 32'(mem_wr), 32'h1);
      check("sw_mem_a", mem_a, 32'h10 + 32'(c - 1));
      check("sw_mem_dout", 32'(mem_dout), 32'(store_bytes[c-1]));
    end
    tick();
    check("sw_done", 32'(ls_done), 32'h1);
    check("sw_mem_wr_off", 32'(mem_wr), 32'h0);
    ls_req = 1'b0;

    // IO byte store held off by a full UART buffer
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41;
    io_buffer_full = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("io_wait_no_wr", 32'(mem_wr), 32'h0);
    end
    io_buffer_full = 1'b0;
    tick(); check("io_lag_no_wr", 32'(mem_wr), 32'h0);
    tick();
    check("io_wr", 32'(mem_wr), 32'h1);
    check("io_mem_a", mem_a, 32'h30000);
    check("io_mem_dout", 32'(mem_dout), 32'h41);
    tick();
    check("io_done", 32'(ls_done), 32'h1);
    check("io_wr_off", 32'(mem_wr), 32'h0);
    ls_req = 1'b0;

    // Flush during fetch, pending byte load takes over
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h202;
    tick(); check("fl_mem_a0", mem_a, 32'h100);
    tick(); tick();
    flush = 1'b1;
    tick(); check("fl_no_done4", 32'(if_done), 32'h0);
    flush = 1'b0; if_req = 1'b0;
    tick(); check("fl_no_done5", 32'(if_done), 32'h0);
    tick();
    check("fl_ls_mem_a", mem_a, 32'h202);
    check("fl_no_done6", 32'(if_done), 32'h0);
    tick(); tick();
    check("fl_ls_done", 32'(ls_done), 32'h1);
    check("fl_ls_rdata", ls_rdata, 32'h0000_00AB);
    check("fl_no_done8", 32'(if_done), 32'h0);
    ls_req = 1'b0;

    // Both requests after a load/store grant: fetch goes first
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h202;
    tick();
    tick(); check("tg_fetch_first", mem_a, 32'h100);
    repeat (5) tick();
    check("tg_fetch_done", 32'(if_done), 32'h1);
    if_req = 1'b0;
    tick(); tick(); check("tg_ls_mem_a", mem_a, 32'h202);
    tick(); tick();
    check("tg_ls_done", 32'(ls_done), 32'h1);
    check("tg_ls_rdata", ls_rdata, 32'h0000_00AB);
    ls_req = 1'b0;

    // Word load with rdy_in low for three cycles
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
    tick();
    tick(); check("rdy_mem_a0", mem_a, 32'h200);
    tick(); check("rdy_mem_a1", mem_a, 32'h201);
    rdy_in = 1'b0;
    tick();
    check("rdy_hold_a3", mem_a, 32'h201);
    check("rdy_hold_wr", 32'(mem_wr), 32'h0);
    tick(); tick();
    check("rdy_hold_a5", mem_a, 32'h201);
    check("rdy_hold_done", 32'(ls_done), 32'h0);
    rdy_in = 1'b1;
    tick(); check("rdy_resume_a", mem_a, 32'h202);
    tick(); tick(); check("rdy_done_early", 32'(ls_done), 32'h0);
    tick();
    check("rdy_done", 32'(ls_done), 32'h1);
    check("rdy_rdata", ls_rdata, 32'hCDAB_2211);
    ls_req = 1'b0;

    // Store masked by rdy_in, then reset mid-store
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h20; ls_wdata = 32'h0102_0304;
    tick();
    tick(); check("mr_wr1", 32'(mem_wr), 32'h1);
    rdy_in = 1'b0; #1;
    check("mr_wr_masked", 32'(mem_wr), 32'h0);
    rdy_in = 1'b1;
    tick();
    check("mr_wr2", 32'(mem_wr), 32'h1);
    check("mr_mem_a2", mem_a, 32'h21);
    rst_in = 1'b1; ls_req = 1'b0;
    tick();
    check("mr_rst_mem_a", mem_a, 32'h0);
    check("mr_rst_mem_dout", 32'(mem_dout), 32'h0);
    check("mr_rst_mem_wr", 32'(mem_wr), 32'h0);
    check("mr_rst_if_done", 32'(if_done), 32'h0);
    check("mr_rst_ls_done", 32'(ls_done), 32'h0);
    check("mr_rst_if_data", if_data, 32'h0);
    check("mr_rst_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick(); check("mr_idle_grant", mem_a, 32'h100);
    repeat (5) tick();
    check("mr_fetch_done", 32'(if_done), 32'h1);
    check("mr_fetch_data", if_data, 32'h0000_0513);
    if_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
